// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_pkg
//  Purpose  : Shared frame-level definitions for the serial word capture
//             block: FSM state encodings and line levels of the frame bits.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

   // Frame receiver states, one serial sample consumed per clock
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   // Line levels of the framing bits
   localparam logic START_BIT  = 1'b1;
   localparam logic STOP_BIT   = 1'b0;
   localparam logic IDLE_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/word_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module   : word_hold_reg
//  Purpose  : One-entry valid/ready holding register. Loads a new word when
//             empty or draining on the same cycle; otherwise drops the word
//             and raises a sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module word_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_overrun;

   // A held word leaves when accepted; an incoming word may refill the slot
   // on that very cycle, so the register never goes empty between them.
   logic w_accept;
   assign w_accept = r_valid & i_ready;

   // Slot contents, occupancy and overrun bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_load) begin
            if (!r_valid || w_accept) begin
               r_data  <= i_load_data;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/serial_word_capture.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_capture
//  Purpose  : Frames a serial bitstream (start, WIDTH data bits MSB first,
//             optional even parity, stop), presents good words on a
//             one-entry valid/ready register and flags parity, framing and
//             overrun errors.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_word_capture
   import serial_frame_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun
);

   localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   frame_state_t       r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_shreg;
   logic               r_par_ok;

   // A good word is recognised combinationally on the stop-bit sample so
   // that the holding register shows it right after that same edge.
   logic w_good_word;
   assign w_good_word = (r_state == STOP) && (serial_in == STOP_BIT) && r_par_ok;

   // Frame receiver: bit counting, data shifting, parity check, error pulses
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_shreg    <= '0;
         r_par_ok   <= 1'b1;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (serial_in == START_BIT) begin
                  r_cnt    <= '0;
                  // Without a parity bit every frame counts as parity-clean
                  r_par_ok <= 1'b1;
                  r_state  <= DATA;
               end
            end
            DATA: begin
               r_shreg <= {r_shreg[WIDTH-2:0], serial_in};
               // Counter parks on its last value instead of wrapping
               if (r_cnt == c_last) begin
                  r_state <= PARITY_EN ? PARITY : STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PARITY: begin
               r_par_ok <= ((^r_shreg) ^ serial_in) == 1'b0;
               r_state  <= STOP;
            end
            STOP: begin
               // A high stop sample is a framing error, never a new start bit
               r_state <= IDLE;
               if (serial_in != STOP_BIT) begin
                  frame_err <= 1'b1;
               end else if (!r_par_ok) begin
                  parity_err <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   word_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk         (clock),
      .rst         (clear),
      .i_load      (w_good_word),
      .i_load_data (r_shreg),
      .i_ready     (data_ready),
      .o_data      (data_out),
      .o_valid     (data_valid),
      .o_overrun   (overrun)
   );

endmodule
`default_nettype wire

// File: tb/tb_serial_word_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_capture
//  Purpose  : Self-checking bench for serial_word_capture (WIDTH=4, even
//             parity). Directed frames followed by randomized frames, checked
//             against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_capture;

   localparam int K_NONE = 0;
   localparam int K_GOOD = 1;
   localparam int K_PE   = 2;
   localparam int K_FE   = 3;

   logic       clock = 1'b0;
   logic       clear;
   logic       serial_in;
   logic       data_ready;
   logic [3:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model of what the consumer should see
   logic       mv;
   logic       movr;
   logic [3:0] md;
   bit         rand_ready = 1'b0;

   always #5 clock = ~clock;

   serial_word_capture #(
      .WIDTH     (4),
      .PARITY_EN (1'b1)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   // Outcome of a complete frame from its data, parity and stop bits
   function automatic int frame_kind(input logic [3:0] d, input logic p, input logic s);
      if (s) return K_FE;
      if (($countones({d, p}) % 2) != 0) return K_PE;
      return K_GOOD;
   endfunction

   function automatic logic even_par(input logic [3:0] d);
      return 1'($countones(d) % 2);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive a serial bit, advance the model, compare outputs
   task automatic step(input logic b, input int kind, input logic [3:0] w);
      if (rand_ready) data_ready = 1'($urandom_range(0, 1));
      serial_in = b;
      @(posedge clock);
      if (clear) begin
         mv   = 1'b0;
         md   = 4'h0;
         movr = 1'b0;
      end else if (kind == K_GOOD) begin
         if (!mv || data_ready) begin
            mv = 1'b1;
            md = w;
         end else begin
            movr = 1'b1;
         end
      end else if (mv && data_ready) begin
         mv = 1'b0;
      end
      #1;
      check("data_valid", 16'(data_valid), 16'(mv));
      if (mv || clear) check("data_out", 16'(data_out), 16'(md));
      check("overrun", 16'(overrun), 16'(movr));
      check("parity_err", 16'(parity_err), 16'(kind == K_PE && !clear));
      check("frame_err", 16'(frame_err), 16'(kind == K_FE && !clear));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, K_NONE, 4'h0);
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
      step(1'b1, K_NONE, 4'h0);
      for (int i = 3; i >= 0; i--) step(d[i], K_NONE, 4'h0);
      step(p, K_NONE, 4'h0);
      step(s, frame_kind(d, p, s), d);
   endtask

   task automatic good_frame(input logic [3:0] d);
      send_frame(d, even_par(d), 1'b0);
   endtask

   initial begin
      logic [3:0] d;
      logic [3:0] wa;
      int         r;

      clear      = 1'b1;
      serial_in  = 1'b0;
      data_ready = 1'b1;
      mv         = 1'b0;
      movr       = 1'b0;
      md         = 4'h0;

      // Reset state
      idle(2);
      clear = 1'b0;
      idle(1);

      // Good word 0xB, presented for one cycle with ready high
      send_frame(4'hB, 1'b1, 1'b0);
      idle(2);

      // Parity mismatch: word dropped
      send_frame(4'h6, 1'b1, 1'b0);
      idle(2);

      // Framing error; trailing idle zeros must not form a frame
      send_frame(4'h5, 1'b0, 1'b1);
      idle(8);

      // Overrun: consumer stalls across two back-to-back good frames
      data_ready = 1'b0;
      good_frame(4'h3);
      good_frame(4'hC);
      idle(2);
      data_ready = 1'b1;
      idle(2);

      // Clear in the middle of the data bits of 0x9, then a full 0x6 frame
      step(1'b1, K_NONE, 4'h0);
      step(1'b1, K_NONE, 4'h0);
      step(1'b0, K_NONE, 4'h0);
      clear = 1'b1;
      step(1'b0, K_NONE, 4'h0);
      clear = 1'b0;
      good_frame(4'h6);
      idle(2);

      // Held word accepted on the same cycle a good 0xA lands
      data_ready = 1'b0;
      good_frame(4'h5);
      wa = 4'hA;
      step(1'b1, K_NONE, 4'h0);
      for (int i = 3; i >= 0; i--) step(wa[i], K_NONE, 4'h0);
      step(even_par(wa), K_NONE, 4'h0);
      data_ready = 1'b1;
      step(1'b0, K_GOOD, wa);
      idle(2);

      // Randomized frames, gaps and consumer back-pressure
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         d = 4'($urandom);
         r = int'($urandom_range(0, 9));
         if (r == 0)      send_frame(d, even_par(d), 1'b1);
         else if (r == 1) send_frame(d, ~even_par(d), 1'b0);
         else             good_frame(d);
         idle(int'($urandom_range(0, 2)));
      end
      rand_ready = 1'b0;
      data_ready = 1'b1;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
